// File: rtl/rf_access_ctrl_pkg.sv
// Shared encodings for the register-file access controller: FSM states,
// access-size codes and default bus widths.
package rf_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_H,
        RD2,
        WR_L,
        FIN
    } state_t;

    localparam logic [1:0] SZ_LO  = 2'b00;
    localparam logic [1:0] SZ_HI  = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

endpackage

// File: rtl/rf_access_ctrl_if.sv
// Requester-side handshake bundle; one instance each for the CPU and the
// debug/loader port.
interface rf_req_if
    import rf_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;

    modport master (output req, wr, size, addr_a, addr_b, wdata, input gnt, done);
    modport slave  (input req, wr, size, addr_a, addr_b, wdata, output gnt, done);

endinterface

// File: rtl/rf_access_ctrl_rr_arbiter.sv
// Two-way arbiter (bit 0 = cpu, bit 1 = dbg), fixed priority or round-robin.
// The pointer remembers which side was granted last.
module rf_rr_arbiter #(
    parameter bit ARB_RR = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_dbg_q;
    logic last_dbg_d;

    // On a tie in round-robin mode the side not granted last wins.
    always_comb begin
        gnt        = 2'b00;
        last_dbg_d = last_dbg_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (ARB_RR && !last_dbg_q) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
            if (gnt[1]) begin
                last_dbg_d = 1'b1;
            end else if (gnt[0]) begin
                last_dbg_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dbg_q <= 1'b0;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Shares the 16x32 register file between CPU and debug port and sequences
// the read-modify-write passes the RF needs for half-word and word writes.
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit ARB_RR  = 1'b0,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    rf_req_if.slave           cpu,
    rf_req_if.slave           dbg,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_reg_port1,
    output logic [ADDR_W-1:0] rf_reg_port2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_we,
    output logic              rf_hl,
    input  logic [DATA_W-1:0] rf_reg_out1,
    input  logic [DATA_W-1:0] rf_reg_out2
);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              cpu_done_q, cpu_done_d;
    logic              dbg_done_q, dbg_done_d;
    logic [1:0]        gnt;
    logic              suppress_we;

    rf_rr_arbiter #(.ARB_RR(ARB_RR)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({dbg.req, cpu.req}),
        .en    (state_q == IDLE),
        .gnt   (gnt)
    );

    assign cpu.gnt  = gnt[0];
    assign dbg.gnt  = gnt[1];
    assign cpu.done = cpu_done_q;
    assign dbg.done = dbg_done_q;
    assign rdata1   = rdata1_q;
    assign rdata2   = rdata2_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        wdata_d    = wdata_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        cpu_done_d = 1'b0;
        dbg_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d  = gnt[1];
                    wr_d     = gnt[1] ? dbg.wr     : cpu.wr;
                    size_d   = gnt[1] ? dbg.size   : cpu.size;
                    addr_a_d = gnt[1] ? dbg.addr_a : cpu.addr_a;
                    addr_b_d = gnt[1] ? dbg.addr_b : cpu.addr_b;
                    wdata_d  = gnt[1] ? dbg.wdata  : cpu.wdata;
                    state_d  = RD;
                end
            end
            RD: begin
                if (!wr_q) begin
                    state_d = FIN;
                end else begin
                    case (size_q)
                        SZ_LO:      state_d = WR_L;
                        SZ_HI, SZ_W: state_d = WR_H;
                        default:    state_d = FIN;
                    endcase
                end
            end
            WR_H:    state_d = (size_q == SZ_W) ? RD2 : FIN;
            RD2:     state_d = WR_L;
            WR_L:    state_d = FIN;
            FIN: begin
                if (!wr_q) begin
                    rdata1_d = rf_reg_out1;
                    rdata2_d = rf_reg_out2;
                end
                if (owner_q) begin
                    dbg_done_d = 1'b1;
                end else begin
                    cpu_done_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RF controls are pure decodes of the state and the latched request;
    // writes to r0 keep their timing but never strobe the RF when R0_ZERO is set.
    assign suppress_we = R0_ZERO && (addr_a_q == '0);

    always_comb begin
        rf_reg_port1 = '0;
        rf_reg_port2 = '0;
        rf_write_reg = '0;
        rf_data_in   = '0;
        rf_we        = 1'b0;
        rf_hl        = 1'b0;
        if (state_q != IDLE) begin
            rf_reg_port1 = addr_a_q;
            rf_reg_port2 = addr_b_q;
            rf_write_reg = addr_a_q;
            rf_data_in   = wdata_q;
        end
        if ((state_q == WR_H) || (state_q == WR_L)) begin
            rf_we = !suppress_we;
        end
        rf_hl = (state_q == WR_H);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            wdata_q    <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            cpu_done_q <= 1'b0;
            dbg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            wdata_q    <= wdata_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            cpu_done_q <= cpu_done_d;
            dbg_done_q <= dbg_done_d;
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: two instances (0 = fixed priority, 1 = round-robin
// with r0 write suppression), each with its own behavioural register file.
module tb_rf_access_ctrl;
    import rf_ctrl_pkg::*;

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] r1;
        logic [31:0] r2;
        int          lat;
        int          weExp;
        int          gntCyc;
        int          weBase;
    } sb_t;

    logic clk = 1'b0;
    logic rstN;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester index p = 2*dut + port, port 0 = cpu, 1 = dbg.
    logic [3:0]  req, wr, gnt, done;
    logic [1:0]  size  [4];
    logic [3:0]  addrA [4];
    logic [3:0]  addrB [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata1 [2];
    logic [31:0] rdata2 [2];
    logic [1:0]  busy, rfQuiet;
    int          weCnt [2];

    logic [31:0] expMem [2][16];
    logic [31:0] lastR1 [2];
    logic [31:0] lastR2 [2];
    sb_t         sb [$];
    int          assertCount = 0;
    int          failCount = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rf_req_if #(.ADDR_W(4), .DATA_W(32)) cpu_port ();
        rf_req_if #(.ADDR_W(4), .DATA_W(32)) dbg_port ();
        logic [3:0]  p1, p2, wreg;
        logic [31:0] din, out1, out2;
        logic        we, hl;
        logic [31:0] mem [16] = '{default: '0};
        int          weCount = 0;

        assign cpu_port.req    = req[2*g];
        assign cpu_port.wr     = wr[2*g];
        assign cpu_port.size   = size[2*g];
        assign cpu_port.addr_a = addrA[2*g];
        assign cpu_port.addr_b = addrB[2*g];
        assign cpu_port.wdata  = wdata[2*g];
        assign dbg_port.req    = req[2*g+1];
        assign dbg_port.wr     = wr[2*g+1];
        assign dbg_port.size   = size[2*g+1];
        assign dbg_port.addr_a = addrA[2*g+1];
        assign dbg_port.addr_b = addrB[2*g+1];
        assign dbg_port.wdata  = wdata[2*g+1];
        assign gnt[2*g]        = cpu_port.gnt;
        assign gnt[2*g+1]      = dbg_port.gnt;
        assign done[2*g]       = cpu_port.done;
        assign done[2*g+1]     = dbg_port.done;
        assign weCnt[g]        = weCount;
        assign rfQuiet[g]      = we | hl | (|p1) | (|p2) | (|wreg) | (|din);

        rf_access_ctrl #(
            .ADDR_W  (4),
            .DATA_W  (32),
            .ARB_RR  (1'(g)),
            .R0_ZERO (1'(g))
        ) dut (
            .clk          (clk),
            .reset        (rstN),
            .cpu          (cpu_port),
            .dbg          (dbg_port),
            .rdata1       (rdata1[g]),
            .rdata2       (rdata2[g]),
            .busy         (busy[g]),
            .rf_reg_port1 (p1),
            .rf_reg_port2 (p2),
            .rf_write_reg (wreg),
            .rf_data_in   (din),
            .rf_we        (we),
            .rf_hl        (hl),
            .rf_reg_out1  (out1),
            .rf_reg_out2  (out2)
        );

        // Register file: registered reads when we=0, half writes merged with out1.
        always @(posedge clk) begin
            if (we) begin
                mem[wreg] <= hl ? {din[31:16], out1[15:0]} : {out1[31:16], din[15:0]};
                weCount   <= weCount + 1;
            end else begin
                out1 <= mem[p1];
                out2 <= mem[p2];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        req  = '0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_busy", 32'(busy[g]), 32'd0);
            check("reset_rdata1", rdata1[g], 32'd0);
            check("reset_rdata2", rdata2[g], 32'd0);
            check("reset_rf_outputs", 32'(rfQuiet[g]), 32'd0);
            lastR1[g] = '0;
            lastR2[g] = '0;
        end
        check("reset_done", 32'(done), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int g, input int port, input logic w, input logic [1:0] sz,
                                 input logic [3:0] a, input logic [3:0] b, input logic [31:0] wd);
        int   p;
        int   n;
        sb_t  e;
        logic suppress;
        p = 2*g + port;
        @(negedge clk);
        req[p]   = 1'b1;
        wr[p]    = w;
        size[p]  = sz;
        addrA[p] = a;
        addrB[p] = b;
        wdata[p] = wd;
        #1;
        n = 0;
        while (gnt[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("gnt", 32'(gnt[p]), 32'd1);
        e.dut    = g;
        e.port   = port;
        e.gntCyc = cyc;
        e.weBase = weCnt[g];
        suppress = (g == 1) && (a == 4'd0);
        if (!w) begin
            e.lat     = 3;
            e.weExp   = 0;
            e.r1      = expMem[g][a];
            e.r2      = expMem[g][b];
            lastR1[g] = e.r1;
            lastR2[g] = e.r2;
        end else begin
            e.r1 = lastR1[g];
            e.r2 = lastR2[g];
            case (sz)
                SZ_LO: begin
                    e.lat = 4; e.weExp = 1;
                    if (!suppress) expMem[g][a] = {expMem[g][a][31:16], wd[15:0]};
                end
                SZ_HI: begin
                    e.lat = 4; e.weExp = 1;
                    if (!suppress) expMem[g][a] = {wd[31:16], expMem[g][a][15:0]};
                end
                SZ_W: begin
                    e.lat = 6; e.weExp = 2;
                    if (!suppress) expMem[g][a] = wd;
                end
                default: begin
                    e.lat = 3; e.weExp = 0;
                end
            endcase
            if (suppress) e.weExp = 0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req[p] = 1'b0;
    endtask

    task automatic checkOutput();
        sb_t e;
        int  p;
        int  n;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        p = 2*e.dut + e.port;
        n = 0;
        while (done[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done", 32'(done[p]), 32'd1);
        check("latency", cyc - e.gntCyc, e.lat);
        check("rdata1", rdata1[e.dut], e.r1);
        check("rdata2", rdata2[e.dut], e.r2);
        check("other_done", 32'(done[p^1]), 32'd0);
        check("busy_at_done", 32'(busy[e.dut]), 32'd0);
        check("we_cycles", weCnt[e.dut] - e.weBase, e.weExp);
        @(negedge clk);
        check("done_pulse_width", 32'(done[p]), 32'd0);
    endtask

    task automatic arbTest(input int g, input logic [3:0] order);
        int n;
        int grants;
        grants = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            req[2*g+i]   = 1'b1;
            wr[2*g+i]    = 1'b0;
            size[2*g+i]  = SZ_W;
            addrA[2*g+i] = 4'd1;
            addrB[2*g+i] = 4'd2;
        end
        n = 0;
        while (grants < 4 && n < 60) begin
            #1;
            if (gnt[2*g] || gnt[2*g+1]) begin
                check("arb_onehot", 32'(gnt[2*g] & gnt[2*g+1]), 32'd0);
                check("arb_winner", 32'(gnt[2*g+1]), 32'(order[grants]));
                grants++;
            end
            @(negedge clk);
            n++;
        end
        check("arb_grant_count", grants, 4);
        req[2*g]   = 1'b0;
        req[2*g+1] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] saved;
        logic        anyDone;
        rstN = 1'b0;
        req  = '0;
        wr   = '0;
        for (int p = 0; p < 4; p++) begin
            size[p] = SZ_LO; addrA[p] = '0; addrB[p] = '0; wdata[p] = '0;
        end
        for (int g = 0; g < 2; g++)
            for (int r = 0; r < 16; r++) expMem[g][r] = '0;

        doReset();

        $display("[TB] word write and read back");
        applyStimulus(0, 0, 1'b1, SZ_W, 4'd3, 4'd0, 32'hDEADBEEF); checkOutput();
        applyStimulus(0, 0, 1'b0, SZ_W, 4'd3, 4'd0, 32'h0);        checkOutput();

        $display("[TB] half-word merges from the debug port");
        applyStimulus(0, 1, 1'b1, SZ_W,  4'd5, 4'd0, 32'h11112222); checkOutput();
        applyStimulus(0, 1, 1'b1, SZ_LO, 4'd5, 4'd0, 32'h0000ABCD); checkOutput();
        applyStimulus(0, 1, 1'b0, SZ_W,  4'd5, 4'd3, 32'h0);        checkOutput();
        applyStimulus(0, 1, 1'b1, SZ_HI, 4'd5, 4'd0, 32'h55550000); checkOutput();
        applyStimulus(0, 1, 1'b0, SZ_W,  4'd5, 4'd5, 32'h0);        checkOutput();

        $display("[TB] r0 write suppression");
        applyStimulus(1, 0, 1'b1, SZ_W, 4'd0, 4'd0, 32'hFFFFFFFF); checkOutput();
        applyStimulus(1, 0, 1'b0, SZ_W, 4'd0, 4'd0, 32'h0);        checkOutput();

        $display("[TB] reserved size write");
        applyStimulus(0, 0, 1'b1, SZ_RSV, 4'd3, 4'd0, 32'h12345678); checkOutput();
        applyStimulus(0, 0, 1'b0, SZ_W,   4'd3, 4'd5, 32'h0);        checkOutput();

        $display("[TB] reset during upper-half write");
        saved = expMem[0][7];
        applyStimulus(0, 0, 1'b1, SZ_W, 4'd7, 4'd0, 32'hCAFEF00D);
        void'(sb.pop_back());
        expMem[0][7] = saved;
        @(posedge clk);
        #2;
        check("wr_h_we", 32'(g_dut[0].we), 32'd1);
        rstN = 1'b0;
        #1;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_we", 32'(g_dut[0].we), 32'd0);
        anyDone = 1'b0;
        repeat (6) begin
            @(negedge clk);
            anyDone = anyDone | (|done);
        end
        check("abort_no_done", 32'(anyDone), 32'd0);
        rstN = 1'b1;
        for (int g = 0; g < 2; g++) begin
            lastR1[g] = '0;
            lastR2[g] = '0;
        end
        applyStimulus(0, 0, 1'b0, SZ_W, 4'd7, 4'd3, 32'h0); checkOutput();

        $display("[TB] arbitration with both requesters held");
        doReset();
        arbTest(1, 4'b0101);
        arbTest(0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
